// File: rtl/apb_protocol_checker.sv
// Passive APB3 protocol checker: follows the IDLE/SETUP/ACCESS phase of a snooped bus,
// latches sticky violation flags and keeps saturating transfer statistics.
module apb_protocol_checker #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic                  clr,
    output logic [4:0]            viol_vec,
    output logic                  viol_pulse,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  slverr_cnt,
    output logic [CNT_WIDTH-1:0]  max_wait
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam int V_HANDSHAKE = 0;
    localparam int V_EN_NO_SEL = 1;
    localparam int V_EN_SETUP  = 2;
    localparam int V_UNSTABLE  = 3;
    localparam int V_TIMEOUT   = 4;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0]            state_reg,     state_next;
    logic [ADDR_WIDTH-1:0] cap_addr_reg,  cap_addr_next;
    logic                  cap_write_reg, cap_write_next;
    logic [DATA_WIDTH-1:0] cap_wdata_reg, cap_wdata_next;
    logic [CNT_WIDTH-1:0]  wait_reg,      wait_next;
    logic [4:0]            viol_vec_reg,  viol_vec_next;
    logic                  viol_pulse_reg;
    logic [CNT_WIDTH-1:0]  max_wait_reg,  max_wait_next;
    logic [CNT_WIDTH-1:0]  max_wait_base;

    logic [4:0]            new_viol;
    logic                  complete;
    logic                  ctrl_mismatch;
    logic                  data_mismatch;
    logic [2:0]            cnt_inc;
    logic [2:0][CNT_WIDTH-1:0] cnt_vec;

    assign ctrl_mismatch = (paddr != cap_addr_reg) || (pwrite != cap_write_reg);
    assign data_mismatch = cap_write_reg && (pwdata != cap_wdata_reg);

    always_comb begin
        state_next     = state_reg;
        cap_addr_next  = cap_addr_reg;
        cap_write_next = cap_write_reg;
        cap_wdata_next = cap_wdata_reg;
        wait_next      = wait_reg;
        new_viol       = '0;
        complete       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (psel) begin
                    cap_addr_next  = paddr;
                    cap_write_next = pwrite;
                    cap_wdata_next = pwdata;
                    if (penable) begin
                        // Enable without a setup phase: resync straight into ACCESS
                        new_viol[V_EN_SETUP] = 1'b1;
                        state_next           = ST_ACCESS;
                        wait_next            = '0;
                    end else begin
                        state_next = ST_SETUP;
                    end
                end else if (penable) begin
                    new_viol[V_EN_NO_SEL] = 1'b1;
                end
            end
            ST_SETUP: begin
                new_viol[V_UNSTABLE] = ctrl_mismatch;
                if (psel && penable) begin
                    state_next = ST_ACCESS;
                    wait_next  = '0;
                end else begin
                    new_viol[V_HANDSHAKE] = 1'b1;
                    if (psel) begin
                        cap_addr_next  = paddr;
                        cap_write_next = pwrite;
                        cap_wdata_next = pwdata;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_ACCESS: begin
                new_viol[V_UNSTABLE] = ctrl_mismatch || data_mismatch;
                if (psel && penable) begin
                    if (pready) begin
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (wait_reg != CNT_MAX) begin
                        // The counter only crosses TIMEOUT once, so this fires once per transfer
                        wait_next             = wait_reg + CNT_ONE;
                        new_viol[V_TIMEOUT]   = (wait_reg == TIMEOUT_M1);
                    end
                end else begin
                    new_viol[V_HANDSHAKE] = 1'b1;
                    new_viol[V_EN_NO_SEL] = penable;
                    state_next            = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // clr wipes the history first so that events on the same edge still register
    assign viol_vec_next = (clr ? 5'd0 : viol_vec_reg) | new_viol;
    assign max_wait_base = clr ? '0 : max_wait_reg;
    assign max_wait_next = (complete && (wait_reg > max_wait_base)) ? wait_reg : max_wait_base;

    assign cnt_inc[0] = complete && cap_write_reg;
    assign cnt_inc[1] = complete && !cap_write_reg;
    assign cnt_inc[2] = complete && pslverr;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [CNT_WIDTH-1:0] cnt_base;
            logic [CNT_WIDTH-1:0] cnt_next;

            assign cnt_base = clr ? '0 : cnt_reg;
            assign cnt_next = (cnt_inc[gi] && (cnt_base != CNT_MAX)) ? cnt_base + CNT_ONE : cnt_base;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_vec[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cap_addr_reg   <= '0;
            cap_write_reg  <= 1'b0;
            cap_wdata_reg  <= '0;
            wait_reg       <= '0;
            viol_vec_reg   <= '0;
            viol_pulse_reg <= 1'b0;
            max_wait_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cap_addr_reg   <= cap_addr_next;
            cap_write_reg  <= cap_write_next;
            cap_wdata_reg  <= cap_wdata_next;
            wait_reg       <= wait_next;
            viol_vec_reg   <= viol_vec_next;
            viol_pulse_reg <= |new_viol;
            max_wait_reg   <= max_wait_next;
        end
    end

    assign viol_vec   = viol_vec_reg;
    assign viol_pulse = viol_pulse_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign wr_cnt     = cnt_vec[0];
    assign rd_cnt     = cnt_vec[1];
    assign slverr_cnt = cnt_vec[2];
    assign max_wait   = max_wait_reg;

endmodule
